// File: rtl/datamem_arb.sv
// datamem_arb: byte-enabled single-storage data memory shared by two requesters.
//   Port A is the scalar core LSU, port B the vector coprocessor LSU.
//   One access per cycle; fixed-priority (A over B) or round-robin arbitration.
//   Reads and out-of-range accesses return a response READ_LAT (1 or 2) cycles
//   after the grant edge, on the granted port, in grant order.
// Ports:
//   core_clk, nrst            clock, synchronous active-low reset
//   x_req/x_we/x_addr/x_wdata request and its fields (x = a | b), held until gnt
//   x_gnt                     combinational grant, access executes at this edge
//   x_rvalid/x_rdata/x_err    registered one-cycle response; rdata holds otherwise
module datamem_arb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ARB_RR   = 1
) (
  input  logic                core_clk,
  input  logic                nrst,
  input  logic                a_req,
  input  logic [DATA_W/8-1:0] a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_err,
  input  logic                b_req,
  input  logic [DATA_W/8-1:0] b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_err
);

  localparam int unsigned NB = DATA_W / 8;

  localparam logic [0:0] PORT_A = 1'b0;
  localparam logic [0:0] PORT_B = 1'b1;

  // One response pipeline stage.
  typedef struct packed {
    logic              valid;
    logic              port;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              last_grant;
  logic              acc;
  logic [NB-1:0]     sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic              is_write;
  rsp_t              rsp_in;
  rsp_t              rsp_fin;
  logic              fin_a;
  logic              fin_b;

  // Arbitration: a tie goes to the port that did not win last (RR) or to A.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (nrst) begin
      if (a_req && b_req) begin
        if ((ARB_RR != 0) && (last_grant == PORT_A)) begin
          b_gnt = 1'b1;
        end else begin
          a_gnt = 1'b1;
        end
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (!nrst) begin
      last_grant <= PORT_B;
    end else if (a_gnt) begin
      last_grant <= PORT_A;
    end else if (b_gnt) begin
      last_grant <= PORT_B;
    end
  end

  // Granted request fields and the response it launches.
  always_comb begin
    acc       = a_gnt || b_gnt;
    sel_we    = b_gnt ? b_we    : a_we;
    sel_addr  = b_gnt ? b_addr  : a_addr;
    sel_wdata = b_gnt ? b_wdata : a_wdata;
    in_range  = 32'(sel_addr) < DEPTH;
    is_write  = |sel_we;
    rsp_in       = '0;
    rsp_in.valid = acc && (!is_write || !in_range);
    rsp_in.port  = b_gnt;
    rsp_in.err   = !in_range;
    if (in_range && !is_write) begin
      rsp_in.data = mem[sel_addr];
    end
  end

  // Storage: never reset; only in-range lanes with we set are written.
  always_ff @(posedge core_clk) begin
    if (acc && is_write && in_range) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (sel_we[i]) begin
          mem[sel_addr][i*8 +: 8] <= sel_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Optional extra stage for READ_LAT=2; reset drops anything in flight.
  if (READ_LAT >= 2) begin : g_lat2
    rsp_t rsp_q;
    always_ff @(posedge core_clk) begin
      if (!nrst) begin
        rsp_q <= '0;
      end else begin
        rsp_q <= rsp_in;
      end
    end
    assign rsp_fin = rsp_q;
  end else begin : g_lat1
    assign rsp_fin = rsp_in;
  end

  assign fin_a = rsp_fin.valid && (rsp_fin.port == PORT_A);
  assign fin_b = rsp_fin.valid && (rsp_fin.port == PORT_B);

  // Per-port output registers; rdata keeps its last value between pulses.
  always_ff @(posedge core_clk) begin
    if (!nrst) begin
      a_rvalid <= 1'b0;
      a_err    <= 1'b0;
      a_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_err    <= 1'b0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= fin_a;
      a_err    <= fin_a && rsp_fin.err;
      b_rvalid <= fin_b;
      b_err    <= fin_b && rsp_fin.err;
      if (fin_a) begin
        a_rdata <= rsp_fin.data;
      end
      if (fin_b) begin
        b_rdata <= rsp_fin.data;
      end
    end
  end

endmodule

// File: tb/tb_datamem_arb.sv
// Bench for datamem_arb: two instances.
//   da: DATA_W=32 ADDR_W=10 DEPTH=1000 READ_LAT=1 round-robin
//   db: DATA_W=64 ADDR_W=6  DEPTH=64   READ_LAT=2 fixed priority
// Each grant updates a memory model and pushes the expected response into a
// per-instance queue; responses are popped and compared as they appear.
module tb_datamem_arb;

  localparam int unsigned DA_DEPTH = 1000;
  localparam int unsigned DA_LAT   = 1;
  localparam int unsigned DB_DEPTH = 64;
  localparam int unsigned DB_LAT   = 2;

  logic core_clk = 1'b0;
  logic nrst     = 1'b0;
  always #5 core_clk = ~core_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  logic        da_a_req = 0, da_b_req = 0;
  logic [3:0]  da_a_we = 0, da_b_we = 0;
  logic [9:0]  da_a_addr = 0, da_b_addr = 0;
  logic [31:0] da_a_wdata = 0, da_b_wdata = 0;
  logic        da_a_gnt, da_b_gnt, da_a_rvalid, da_b_rvalid, da_a_err, da_b_err;
  logic [31:0] da_a_rdata, da_b_rdata;

  logic        db_a_req = 0, db_b_req = 0;
  logic [7:0]  db_a_we = 0, db_b_we = 0;
  logic [5:0]  db_a_addr = 0, db_b_addr = 0;
  logic [63:0] db_a_wdata = 0, db_b_wdata = 0;
  logic        db_a_gnt, db_b_gnt, db_a_rvalid, db_b_rvalid, db_a_err, db_b_err;
  logic [63:0] db_a_rdata, db_b_rdata;

  typedef struct {
    logic        port;
    logic        err;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] ma [DA_DEPTH];
  logic [63:0] mb [DB_DEPTH];

  datamem_arb #(.DATA_W(32), .ADDR_W(10), .DEPTH(DA_DEPTH), .READ_LAT(DA_LAT), .ARB_RR(1)) u_da (
    .core_clk(core_clk), .nrst(nrst),
    .a_req(da_a_req), .a_we(da_a_we), .a_addr(da_a_addr), .a_wdata(da_a_wdata),
    .a_gnt(da_a_gnt), .a_rvalid(da_a_rvalid), .a_rdata(da_a_rdata), .a_err(da_a_err),
    .b_req(da_b_req), .b_we(da_b_we), .b_addr(da_b_addr), .b_wdata(da_b_wdata),
    .b_gnt(da_b_gnt), .b_rvalid(da_b_rvalid), .b_rdata(da_b_rdata), .b_err(da_b_err)
  );

  datamem_arb #(.DATA_W(64), .ADDR_W(6), .DEPTH(DB_DEPTH), .READ_LAT(DB_LAT), .ARB_RR(0)) u_db (
    .core_clk(core_clk), .nrst(nrst),
    .a_req(db_a_req), .a_we(db_a_we), .a_addr(db_a_addr), .a_wdata(db_a_wdata),
    .a_gnt(db_a_gnt), .a_rvalid(db_a_rvalid), .a_rdata(db_a_rdata), .a_err(db_a_err),
    .b_req(db_b_req), .b_we(db_b_we), .b_addr(db_b_addr), .b_wdata(db_b_wdata),
    .b_gnt(db_b_gnt), .b_rvalid(db_b_rvalid), .b_rdata(db_b_rdata), .b_err(db_b_err)
  );

  // Scoreboard for da: compare responses, then record this cycle's grant.
  always @(negedge core_clk) begin : sb_da
    exp_t        e;
    logic        p;
    logic [3:0]  we;
    logic [9:0]  ad;
    logic [31:0] wd;
    logic [31:0] got_d;
    logic        got_e;
    if (da_a_rvalid || da_b_rvalid) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL da_unexpected_rvalid: got a=%0b b=%0b at cycle %0d, required none", da_a_rvalid, da_b_rvalid, cyc);
      end else begin
        e     = qa.pop_front();
        got_d = e.port ? da_b_rdata : da_a_rdata;
        got_e = e.port ? da_b_err : da_a_err;
        if ({da_b_rvalid, da_a_rvalid} !== (e.port ? 2'b10 : 2'b01) || got_e !== e.err ||
            got_d !== e.data[31:0] || cyc != e.due) begin
          errors++;
          $display("FAIL da_response: got rvalid(b,a)=%b err=%b data=%h cyc=%0d, required port=%0d err=%b data=%h cyc=%0d",
                   {da_b_rvalid, da_a_rvalid}, got_e, got_d, cyc, e.port, e.err, e.data[31:0], e.due);
        end
      end
    end else if (qa.size() != 0 && qa[0].due <= cyc) begin
      checks++;
      errors++;
      e = qa.pop_front();
      $display("FAIL da_missing_rvalid: got none at cycle %0d, required port=%0d data=%h", cyc, e.port, e.data[31:0]);
    end
    if (da_a_gnt || da_b_gnt) begin
      p  = da_b_gnt;
      we = p ? da_b_we : da_a_we;
      ad = p ? da_b_addr : da_a_addr;
      wd = p ? da_b_wdata : da_a_wdata;
      e.port = p;
      e.due  = cyc + int'(DA_LAT);
      if (32'(ad) >= DA_DEPTH) begin
        e.err = 1'b1; e.data = '0; qa.push_back(e);
      end else if (we != 4'h0) begin
        for (int i = 0; i < 4; i++) if (we[i]) ma[ad][i*8 +: 8] = wd[i*8 +: 8];
      end else begin
        e.err = 1'b0; e.data = 64'(ma[ad]); qa.push_back(e);
      end
    end
  end

  // Scoreboard for db.
  always @(negedge core_clk) begin : sb_db
    exp_t        e;
    logic        p;
    logic [7:0]  we;
    logic [5:0]  ad;
    logic [63:0] wd;
    logic [63:0] got_d;
    logic        got_e;
    if (db_a_rvalid || db_b_rvalid) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL db_unexpected_rvalid: got a=%0b b=%0b at cycle %0d, required none", db_a_rvalid, db_b_rvalid, cyc);
      end else begin
        e     = qb.pop_front();
        got_d = e.port ? db_b_rdata : db_a_rdata;
        got_e = e.port ? db_b_err : db_a_err;
        if ({db_b_rvalid, db_a_rvalid} !== (e.port ? 2'b10 : 2'b01) || got_e !== e.err ||
            got_d !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL db_response: got rvalid(b,a)=%b err=%b data=%h cyc=%0d, required port=%0d err=%b data=%h cyc=%0d",
                   {db_b_rvalid, db_a_rvalid}, got_e, got_d, cyc, e.port, e.err, e.data, e.due);
        end
      end
    end else if (qb.size() != 0 && qb[0].due <= cyc) begin
      checks++;
      errors++;
      e = qb.pop_front();
      $display("FAIL db_missing_rvalid: got none at cycle %0d, required port=%0d data=%h", cyc, e.port, e.data);
    end
    if (db_a_gnt || db_b_gnt) begin
      p  = db_b_gnt;
      we = p ? db_b_we : db_a_we;
      ad = p ? db_b_addr : db_a_addr;
      wd = p ? db_b_wdata : db_a_wdata;
      e.port = p;
      e.due  = cyc + int'(DB_LAT);
      if (we != 8'h00) begin
        for (int i = 0; i < 8; i++) if (we[i]) mb[ad][i*8 +: 8] = wd[i*8 +: 8];
      end else begin
        e.err = 1'b0; e.data = mb[ad]; qb.push_back(e);
      end
    end
  end

  // Single-port drivers: one request per cycle, the other port idle.
  task automatic da_op(input logic p, input logic [3:0] we, input logic [9:0] ad, input logic [31:0] wd);
    @(posedge core_clk); #1;
    da_a_req = !p; da_b_req = p;
    if (p) begin da_b_we = we; da_b_addr = ad; da_b_wdata = wd; end
    else   begin da_a_we = we; da_a_addr = ad; da_a_wdata = wd; end
  endtask

  task automatic db_op(input logic p, input logic [7:0] we, input logic [5:0] ad, input logic [63:0] wd);
    @(posedge core_clk); #1;
    db_a_req = !p; db_b_req = p;
    if (p) begin db_b_we = we; db_b_addr = ad; db_b_wdata = wd; end
    else   begin db_a_we = we; db_a_addr = ad; db_a_wdata = wd; end
  endtask

  task automatic idle_all(input int n);
    @(posedge core_clk); #1;
    da_a_req = 0; da_b_req = 0; db_a_req = 0; db_b_req = 0;
    repeat (n) @(negedge core_clk);
  endtask

  task automatic test_reset;
    da_a_req = 1; da_b_req = 1; db_a_req = 1; db_b_req = 1;
    repeat (3) begin
      @(negedge core_clk);
      checks++;
      if ({da_a_gnt, da_b_gnt, db_a_gnt, db_b_gnt} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_gnt: got %b, required 0000", {da_a_gnt, da_b_gnt, db_a_gnt, db_b_gnt});
      end
    end
    @(posedge core_clk); #1;
    nrst = 1; da_a_req = 0; da_b_req = 0; db_a_req = 0; db_b_req = 0;
    @(negedge core_clk);
    checks++;
    if ({da_a_rvalid, da_b_rvalid, da_a_err, da_b_err, db_a_rvalid, db_b_rvalid, db_a_err, db_b_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000000",
               {da_a_rvalid, da_b_rvalid, da_a_err, da_b_err, db_a_rvalid, db_b_rvalid, db_a_err, db_b_err});
    end
    checks++;
    if (da_a_rdata !== 32'h0 || da_b_rdata !== 32'h0 || db_a_rdata !== 64'h0 || db_b_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h %h %h %h, required all zero", da_a_rdata, da_b_rdata, db_a_rdata, db_b_rdata);
    end
  endtask

  task automatic test_byte_enable;
    for (int i = 0; i < 4; i++) da_op(0, 4'hF, 10'(i), 32'h0);
    for (int i = 0; i < 4; i++) da_op(0, 4'(1 << i), 10'(i), 32'hC1C1C1C1);
    for (int i = 0; i < 4; i++) da_op(i[0], 4'h0, 10'(i), 32'h0);
    idle_all(4);
  endtask

  task automatic test_latency;
    int k;
    logic exp_v;
    da_op(0, 4'hF, 10'd5, 32'hDEADBEEF);
    da_op(1, 4'h0, 10'd5, 32'h0);
    @(negedge core_clk);
    checks++;
    if (da_b_gnt !== 1'b1) begin errors++; $display("FAIL lat1_gnt: got %b, required 1", da_b_gnt); end
    k = cyc;
    idle_all(0);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge core_clk);
      exp_v = (cyc == k + int'(DA_LAT));
      checks++;
      if (da_b_rvalid !== exp_v || da_a_rvalid !== 1'b0 || da_b_rdata !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL lat1_pulse: cyc=%0d got rvalid=%b/%b rdata=%h, required %b/0 DEADBEEF",
                 cyc - k, da_b_rvalid, da_a_rvalid, da_b_rdata, exp_v);
      end
    end
    db_op(1, 8'hFF, 6'd5, 64'h00000000DEADBEEF);
    db_op(0, 8'h00, 6'd5, 64'h0);
    @(negedge core_clk);
    checks++;
    if (db_a_gnt !== 1'b1) begin errors++; $display("FAIL lat2_gnt: got %b, required 1", db_a_gnt); end
    k = cyc;
    idle_all(0);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge core_clk);
      exp_v = (cyc == k + int'(DB_LAT));
      checks++;
      if (db_a_rvalid !== exp_v || db_b_rvalid !== 1'b0 ||
          (cyc >= k + int'(DB_LAT) && db_a_rdata !== 64'h00000000DEADBEEF)) begin
        errors++;
        $display("FAIL lat2_pulse: cyc=%0d got rvalid=%b/%b rdata=%h, required %b/0 DEADBEEF",
                 cyc - k, db_a_rvalid, db_b_rvalid, db_a_rdata, exp_v);
      end
    end
  endtask

  task automatic test_out_of_range;
    da_op(0, 4'hF, 10'd999,  32'hA5A5A5A5);
    da_op(0, 4'hF, 10'd1000, 32'h12345678);
    da_op(1, 4'h0, 10'd1000, 32'h0);
    da_op(1, 4'h3, 10'd1023, 32'hFFFFFFFF);
    da_op(0, 4'h0, 10'd999,  32'h0);
    da_op(1, 4'h0, 10'd0,    32'h0);
    idle_all(4);
  endtask

  task automatic test_rr_contention;
    for (int i = 0; i < 4; i++) da_op(0, 4'hF, 10'(10 + i), 32'h1000_0000 + 32'(i));
    da_op(1, 4'h0, 10'd12, 32'h0);
    @(negedge core_clk);
    checks++;
    if (da_b_gnt !== 1'b1) begin errors++; $display("FAIL rr_setup_gnt: got %b, required 1", da_b_gnt); end
    @(posedge core_clk); #1;
    da_a_req = 1; da_a_we = 0; da_a_addr = 10'd10;
    da_b_req = 1; da_b_we = 0; da_b_addr = 10'd11;
    for (int i = 0; i < 4; i++) begin
      @(negedge core_clk);
      checks++;
      if (da_a_gnt !== ((i % 2) == 0) || da_b_gnt !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got a=%b b=%b, required a=%0d b=%0d", i, da_a_gnt, da_b_gnt, (i % 2) == 0, (i % 2) == 1);
      end
      if (i < 3) begin @(posedge core_clk); #1; end
    end
    idle_all(4);
  endtask

  task automatic test_fixed_priority;
    db_op(0, 8'hFF, 6'd10, 64'h0A0A_0A0A_0000_0010);
    db_op(0, 8'hFF, 6'd20, 64'h0B0B_0B0B_0000_0020);
    db_op(1, 8'h00, 6'd20, 64'h0);
    @(negedge core_clk);
    @(posedge core_clk); #1;
    db_a_req = 1; db_a_we = 0; db_a_addr = 6'd10;
    db_b_req = 1; db_b_we = 0; db_b_addr = 6'd20;
    for (int i = 0; i < 4; i++) begin
      @(negedge core_clk);
      checks++;
      if (db_a_gnt !== 1'b1 || db_b_gnt !== 1'b0) begin
        errors++;
        $display("FAIL fixed_order[%0d]: got a=%b b=%b, required a=1 b=0", i, db_a_gnt, db_b_gnt);
      end
      @(posedge core_clk); #1;
    end
    db_a_req = 0;
    @(negedge core_clk);
    checks++;
    if (db_a_gnt !== 1'b0 || db_b_gnt !== 1'b1) begin
      errors++;
      $display("FAIL fixed_release: got a=%b b=%b, required a=0 b=1", db_a_gnt, db_b_gnt);
    end
    idle_all(5);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) db_op(0, 8'hFF, 6'(32 + i), {32'hB2B00000 + 32'(i), 32'(i * 3)});
    for (int i = 0; i < 8; i++) db_op(1, 8'h00, 6'(32 + i), 64'h0);
    for (int i = 0; i < 4; i++) db_op(i[0], 8'h00, 6'(39 - i), 64'h0);
    idle_all(5);
  endtask

  task automatic test_reset_midflight;
    da_op(0, 4'hF, 10'd30, 32'h3030_3030);
    idle_all(0);
    db_op(0, 8'h00, 6'd5, 64'h0);
    @(negedge core_clk);
    checks++;
    if (db_a_gnt !== 1'b1) begin errors++; $display("FAIL midflight_gnt: got %b, required 1", db_a_gnt); end
    @(posedge core_clk); #1;
    nrst = 0; db_a_req = 0;
    qb.delete();
    repeat (3) begin
      @(negedge core_clk);
      checks++;
      if (db_a_rvalid !== 1'b0 || db_b_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL midflight_in_reset: got rvalid a=%b b=%b, required 0 0", db_a_rvalid, db_b_rvalid);
      end
    end
    @(posedge core_clk); #1;
    nrst = 1;
    da_a_req = 1; da_a_we = 0; da_a_addr = 10'd10;
    da_b_req = 1; da_b_we = 0; da_b_addr = 10'd11;
    @(negedge core_clk);
    checks++;
    if (da_a_gnt !== 1'b1 || da_b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_tie: got a=%b b=%b, required a=1 b=0", da_a_gnt, da_b_gnt);
    end
    @(posedge core_clk); #1;
    da_a_req = 0;
    @(negedge core_clk);
    checks++;
    if (da_b_gnt !== 1'b1) begin errors++; $display("FAIL post_reset_b: got %b, required 1", da_b_gnt); end
    @(posedge core_clk); #1;
    da_b_req = 0;
    repeat (4) begin
      @(negedge core_clk);
      checks++;
      if (db_a_rvalid !== 1'b0 || db_b_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL midflight_after: got rvalid a=%b b=%b, required 0 0", db_a_rvalid, db_b_rvalid);
      end
    end
  endtask

  task automatic test_sweep;
    logic pa = 0, pb = 0, exp_a, exp_b;
    int done = 0, n = 0;
    for (int i = 0; i < 64; i++) db_op(i[0], 8'hFF, 6'(i), {$urandom, $urandom});
    while (done < 10000 && n < 40000) begin
      @(posedge core_clk); #1;
      if (!pa && $urandom_range(9) < 6) begin
        pa = 1;
        db_a_we    = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
        db_a_addr  = 6'($urandom);
        db_a_wdata = {$urandom, $urandom};
      end
      if (!pb && $urandom_range(9) < 6) begin
        pb = 1;
        db_b_we    = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
        db_b_addr  = 6'($urandom);
        db_b_wdata = {$urandom, $urandom};
      end
      db_a_req = pa; db_b_req = pb;
      @(negedge core_clk);
      exp_a = pa;
      exp_b = pb && !pa;
      checks++;
      if (db_a_gnt !== exp_a || db_b_gnt !== exp_b) begin
        errors++;
        $display("FAIL sweep_gnt: got a=%b b=%b, required a=%b b=%b at cycle %0d", db_a_gnt, db_b_gnt, exp_a, exp_b, cyc);
      end
      if (exp_a) begin pa = 0; done++; end
      else if (exp_b) begin pb = 0; done++; end
      n++;
    end
    checks++;
    if (done < 10000) begin errors++; $display("FAIL sweep_budget: got %0d accesses, required 10000", done); end
    idle_all(6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_enable();
    test_latency();
    test_out_of_range();
    test_rr_contention();
    test_fixed_priority();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    idle_all(6);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL leftover_responses: got %0d/%0d pending, required 0/0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datamem_arb.md
# datamem_arb

Parametrised, byte-enabled, single-storage data memory shared by two requesters: port A (scalar core load/store unit) and port B (vector coprocessor load/store unit). It is the successor to the single-port core data memory. It adds configurable width, depth and read latency, a req/gnt/rvalid handshake per port, fixed-priority or round-robin arbitration, and out-of-range error reporting. It sits between both load/store units and the on-chip data RAM.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8; NB = DATA_W/8 byte lanes.
- ADDR_W, 10: word-address width.
- DEPTH, 1024: number of words; must be ≤ 2^ADDR_W and need not be a power of 2.
- READ_LAT, 1: grant-to-rvalid latency in cycles; legal values are 1 and 2.
- ARB_RR, 1: 1 selects round-robin arbitration; 0 selects fixed priority with A over B.
- core_clk, in, 1: sole clock; all state updates on the rising edge.
- nrst, in, 1: reset, synchronous, active-low.
- a_req / b_req, in, 1: access request; held with its fields until the matching gnt.
- a_we / b_we, in, NB: byte write enables; all-zero means read; bit i writes byte lane i.
- a_addr / b_addr, in, ADDR_W: word address.
- a_wdata / b_wdata, in, DATA_W: write data.
- a_gnt / b_gnt, out, 1: combinational; the request is accepted at this cycle's rising edge.
- a_rvalid / b_rvalid, out, 1: one-cycle response pulse.
- a_rdata / b_rdata, out, DATA_W: read data; valid when rvalid=1, holds its last value otherwise.
- a_err / b_err, out, 1: asserted together with rvalid for an out-of-range access.

## Operation
- At most one access per cycle; storage is single-ported.
- Arbitration:
  - Only A requests: A granted.
  - Only B requests: B granted.
  - Both request, ARB_RR=0: A is granted.
  - Both request, ARB_RR=1: the port not in last_grant is granted.
  - last_grant is updated on every grant; it resets to B so that A wins the first tie.
- gnt is 0 whenever nrst=0 or req=0. Fields are sampled only on the granted cycle.
- Write (we≠0, addr<DEPTH): each byte lane with we[i]=1 is updated at the grant edge; other lanes are unchanged.
  - No rvalid is produced.
  - A read granted in the following cycle returns the new data.
- Read (we=0, addr<DEPTH): rvalid pulses on the granted port READ_LAT cycles after the grant edge, with rdata = mem[addr]; err=0.
- Out-of-range access (addr ≥ DEPTH), read or write:
  - Memory is unchanged.
  - rvalid pulses READ_LAT cycles later with rdata=0 and err=1.
- Responses are returned in grant order, on the port that was granted. The pipeline carries {valid, port, err, data} per stage.
- Reset (nrst=0 at an edge):
  - rvalid=0, err=0, rdata=0 on both ports.
  - All pipeline valids are cleared and last_grant=B.
  - Memory contents are not cleared.
  - In-flight reads are dropped and produce no response, including when reset lands mid-pipeline.

## Timing
- Grant is zero-cycle: req high in cycle k with gnt high means the access is executed at edge k.
- READ_LAT=1: rvalid and rdata are registered outputs, visible in cycle k+1.
- READ_LAT=2: one extra register stage; visible in cycle k+2.
- Throughput is one access per cycle in total; back-to-back reads on the same or alternating ports produce back-to-back rvalid pulses.
- A losing requester keeps req high and stalls. In RR mode it is guaranteed a grant within 1 cycle.
- All outputs are 0 in the first cycle after reset is released. A request made in that cycle may be granted.

## Test plan
- **Byte-enable writes:** DATA_W=32, write 0xC1C1C1C1 with we=0001, 0010, 0100, 1000 to addresses 0–3 after preloading 0x00000000, then read each back → 0x000000C1, 0x0000C100, 0x00C10000, 0xC1000000.
- **Latency:** READ_LAT=1 and READ_LAT=2; read address 5 holding 0xDEADBEEF granted at cycle k → rvalid=1 with rdata=0xDEADBEEF exactly at cycle k+1 (resp. k+2), and 0 in all other cycles.
- **Round-robin contention:** ARB_RR=1, a_req=b_req=1 held for 4 cycles → grants A, B, A, B. With ARB_RR=0 → A, A, A, A while B stalls.
- **Out-of-range:** DEPTH=1000, write then read address 1000 → memory unchanged, rvalid=1, err=1, rdata=0 for both accesses.
- **Reset mid-flight:** READ_LAT=2, issue a read, assert nrst=0 one cycle later → no rvalid ever appears; after release, last_grant=B, so a tie grants A first.
- **Parametric sweep:** DATA_W=64, ADDR_W=6, DEPTH=64; random byte-enable traffic on both ports against a scoreboard model → zero mismatches over 10 000 accesses.
